bp_me_wb_client: RTL and testbench

//  Wishbone B4 slave that turns classic WB cycles from an external master into single-beat

---
 rtl/bp_me_wb_client_if.sv | 58 +++++
 rtl/bp_me_wb_client.sv | 170 +++++++++++++++++
 tb/tb_bp_me_wb_client.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_me_wb_client_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_wb_client_if
// Function : Bundles the Wishbone slave port and the BedRock mem_fwd/mem_rev
//            endpoint of bp_me_wb_client.
// Revision : 1.0
// ============================================================================
interface bp_me_wb_client_if #(
    parameter int PADDR_WIDTH  = 40,
    parameter int DATA_WIDTH   = 64,
    parameter int LCE_ID_WIDTH = 8,
    parameter int DID_WIDTH    = 3
);
    // Header layout, MSB first: msg_type[4] | addr | size[3] | lce_id | src_did
    localparam int HDR_W = 4 + PADDR_WIDTH + 3 + LCE_ID_WIDTH + DID_WIDTH;

    logic [HDR_W-1:0]       mem_fwd_header_o;
    logic [DATA_WIDTH-1:0]  mem_fwd_data_o;
    logic                   mem_fwd_v_o;
    logic                   mem_fwd_ready_and_i;
    logic                   mem_fwd_last_o;
    logic [HDR_W-1:0]       mem_rev_header_i;
    logic [DATA_WIDTH-1:0]  mem_rev_data_i;
    logic                   mem_rev_v_i;
    logic                   mem_rev_ready_and_o;
    logic                   mem_rev_last_i;

    logic [PADDR_WIDTH-4:0] adr_i;
    logic [DATA_WIDTH-1:0]  dat_i;
    logic                   cyc_i;
    logic                   stb_i;
    logic                   we_i;
    logic [7:0]             sel_i;
    logic [2:0]             cti_i;
    logic [1:0]             bte_i;
    logic [DATA_WIDTH-1:0]  dat_o;
    logic                   ack_o;
    logic                   err_o;

    modport slave (
        output mem_fwd_header_o, mem_fwd_data_o, mem_fwd_v_o, mem_fwd_last_o,
        input  mem_fwd_ready_and_i,
        input  mem_rev_header_i, mem_rev_data_i, mem_rev_v_i, mem_rev_last_i,
        output mem_rev_ready_and_o,
        input  adr_i, dat_i, cyc_i, stb_i, we_i, sel_i, cti_i, bte_i,
        output dat_o, ack_o, err_o
    );

    modport master (
        input  mem_fwd_header_o, mem_fwd_data_o, mem_fwd_v_o, mem_fwd_last_o,
        output mem_fwd_ready_and_i,
        output mem_rev_header_i, mem_rev_data_i, mem_rev_v_i, mem_rev_last_i,
        input  mem_rev_ready_and_o,
        output adr_i, dat_i, cyc_i, stb_i, we_i, sel_i, cti_i, bte_i,
        input  dat_o, ack_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/bp_me_wb_client.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_wb_client
// Function : Wishbone B4 slave issuing single-beat BedRock uncached commands,
//            one outstanding transaction at a time.
// Revision : 1.0
// ============================================================================
module bp_me_wb_client #(
    parameter int                    PADDR_WIDTH  = 40,
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    LCE_ID_WIDTH = 8,
    parameter int                    DID_WIDTH    = 3,
    parameter logic [LCE_ID_WIDTH-1:0] LCE_ID     = '0,
    parameter logic [DID_WIDTH-1:0]    DID        = '0
) (
    input  wire logic          clk_i,
    input  wire logic          reset_n_i,
    bp_me_wb_client_if.slave   bus
);
    localparam int HDR_W = 4 + PADDR_WIDTH + 3 + LCE_ID_WIDTH + DID_WIDTH;

    localparam logic [3:0] c_MSG_UC_RD = 4'd2;
    localparam logic [3:0] c_MSG_UC_WR = 4'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ACK  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [HDR_W-1:0]      r_hdr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_dat_o;
    logic [2:0]            r_off;

    logic                  w_req;
    logic                  w_legal;
    logic [2:0]            w_off;
    logic [2:0]            w_size;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [DATA_WIDTH-1:0] w_rep;
    logic                  w_fwd_v;
    logic                  w_rev_ready;
    logic                  w_ack;
    logic                  w_err;
    logic                  w_rev_fire;
    logic                  w_unused;

    assign w_req      = bus.cyc_i & bus.stb_i;
    assign w_rev_fire = w_rev_ready & bus.mem_rev_v_i;

    // Byte-select decode: offset of lowest lane and log2 of the access size
    always_comb begin
        w_legal = 1'b1;
        w_off   = 3'd0;
        w_size  = 3'd0;
        case (bus.sel_i)
            8'h01: w_off = 3'd0;
            8'h02: w_off = 3'd1;
            8'h04: w_off = 3'd2;
            8'h08: w_off = 3'd3;
            8'h10: w_off = 3'd4;
            8'h20: w_off = 3'd5;
            8'h40: w_off = 3'd6;
            8'h80: w_off = 3'd7;
            8'h03: w_size = 3'd1;
            8'h0C: begin w_off = 3'd2; w_size = 3'd1; end
            8'h30: begin w_off = 3'd4; w_size = 3'd1; end
            8'hC0: begin w_off = 3'd6; w_size = 3'd1; end
            8'h0F: w_size = 3'd2;
            8'hF0: begin w_off = 3'd4; w_size = 3'd2; end
            8'hFF: w_size = 3'd3;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_shift = bus.dat_i >> {w_off, 3'b000};

    always_comb begin
        w_rep = w_shift;
        case (w_size)
            3'd0:    w_rep = {8{w_shift[7:0]}};
            3'd1:    w_rep = {4{w_shift[15:0]}};
            3'd2:    w_rep = {2{w_shift[31:0]}};
            default: w_rep = w_shift;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A dropped cyc_i never aborts: the BedRock transaction always drains
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = w_legal ? S_SEND : S_ERR;
                end
            end
            S_SEND:  if (bus.mem_fwd_ready_and_i) w_next = S_WAIT;
            S_WAIT:  if (bus.mem_rev_v_i)         w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_fwd_v     = 1'b0;
        w_rev_ready = 1'b0;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_SEND:  w_fwd_v     = 1'b1;
            S_WAIT:  w_rev_ready = 1'b1;
            S_ACK:   w_ack       = 1'b1;
            S_ERR:   w_err       = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hdr   <= '0;
            r_data  <= '0;
            r_off   <= 3'd0;
            r_dat_o <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_req && w_legal) begin
                r_hdr  <= {(bus.we_i ? c_MSG_UC_WR : c_MSG_UC_RD),
                           bus.adr_i, w_off, w_size, LCE_ID, DID};
                r_data <= w_rep;
                r_off  <= w_off;
            end
            if (w_rev_fire && (r_hdr[HDR_W-1 -: 4] == c_MSG_UC_RD)) begin
                r_dat_o <= bus.mem_rev_data_i << {r_off, 3'b000};
            end
        end
    end

    assign bus.mem_fwd_header_o    = r_hdr;
    assign bus.mem_fwd_data_o      = r_data;
    assign bus.mem_fwd_v_o         = w_fwd_v;
    assign bus.mem_fwd_last_o      = w_fwd_v;
    assign bus.mem_rev_ready_and_o = w_rev_ready;
    assign bus.dat_o               = r_dat_o;
    assign bus.ack_o               = w_ack & bus.cyc_i;
    assign bus.err_o               = w_err;

    assign w_unused = ^{bus.cti_i, bus.bte_i, bus.mem_rev_header_i[HDR_W-5:0]};

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (DATA_WIDTH == 64);
            if (w_rev_fire) begin
                assert (bus.mem_rev_last_i);
                assert (bus.mem_rev_header_i[HDR_W-1 -: 4] == r_hdr[HDR_W-1 -: 4]);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bp_me_wb_client.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_me_wb_client
// Function : Directed self-checking bench for bp_me_wb_client.
// Revision : 1.0
// ============================================================================
module tb_bp_me_wb_client;
    localparam int PADDR_WIDTH  = 40;
    localparam int DATA_WIDTH   = 64;
    localparam int LCE_ID_WIDTH = 8;
    localparam int DID_WIDTH    = 3;
    localparam int HDR_W        = 4 + PADDR_WIDTH + 3 + LCE_ID_WIDTH + DID_WIDTH;

    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b1;
    int   n_tests   = 0;
    int   n_fail    = 0;

    always #5 clk_i = ~clk_i;

    bp_me_wb_client_if #(
        .PADDR_WIDTH(PADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .LCE_ID_WIDTH(LCE_ID_WIDTH), .DID_WIDTH(DID_WIDTH)
    ) bus ();

    bp_me_wb_client #(
        .PADDR_WIDTH(PADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .LCE_ID_WIDTH(LCE_ID_WIDTH), .DID_WIDTH(DID_WIDTH),
        .LCE_ID(8'h5A), .DID(3'h5)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    function automatic logic [HDR_W-1:0] mk_hdr(input logic [3:0] msg,
                                                input logic [39:0] addr,
                                                input logic [2:0] size);
        return {msg, addr, size, 8'h5A, 3'h5};
    endfunction

    // Runs one WB cycle starting at a negedge; acts as BedRock responder.
    // term = cycle index of ack/err (-1 on timeout), fwd_n = cycles with fwd_v.
    task automatic do_xfer(input logic [36:0] adr, input logic [7:0] sel, input logic we,
                           input logic [63:0] dat, input logic [2:0] cti, input int stall,
                           input logic [63:0] rdata,
                           output int term, output logic was_err, output int fwd_n,
                           output logic [HDR_W-1:0] hdr, output logic [63:0] fdata,
                           output logic stable, output logic extra);
        int  sc;
        bit  done;
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = adr; bus.sel_i = sel;
        bus.we_i = we; bus.dat_i = dat; bus.cti_i = cti; bus.bte_i = 2'b00;
        term = -1; was_err = 1'b0; fwd_n = 0; hdr = '0; fdata = '0;
        stable = 1'b1; extra = 1'b0; sc = 0; done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            if (bus.mem_fwd_v_o) begin
                if (fwd_n == 0) begin
                    hdr   = bus.mem_fwd_header_o;
                    fdata = bus.mem_fwd_data_o;
                end else if (bus.mem_fwd_header_o !== hdr || bus.mem_fwd_data_o !== fdata) begin
                    stable = 1'b0;
                end
                if (bus.mem_fwd_last_o !== 1'b1) stable = 1'b0;
                fwd_n++;
                bus.mem_fwd_ready_and_i = (sc >= stall);
                sc++;
            end else begin
                bus.mem_fwd_ready_and_i = 1'b0;
            end
            if (bus.mem_rev_ready_and_o) begin
                bus.mem_rev_v_i      = 1'b1;
                bus.mem_rev_header_i = {hdr[HDR_W-1 -: 4], {(HDR_W-4){1'b0}}};
                bus.mem_rev_data_i   = rdata;
            end else begin
                bus.mem_rev_v_i = 1'b0;
            end
            if (bus.ack_o || bus.err_o) begin
                term    = n;
                was_err = bus.err_o;
                done    = 1'b1;
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end
        if (bus.ack_o || bus.err_o) extra = 1'b1;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        bus.mem_fwd_ready_and_i = 1'b0; bus.mem_rev_v_i = 1'b0;
    endtask

    int               t, fn;
    logic             er, st, ex;
    logic [HDR_W-1:0] h;
    logic [63:0]      fd;

    task automatic test_reset();
        bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.sel_i = 0; bus.adr_i = '0;
        bus.dat_i = '0; bus.cti_i = 0; bus.bte_i = 0; bus.mem_fwd_ready_and_i = 0;
        bus.mem_rev_v_i = 0; bus.mem_rev_last_i = 1; bus.mem_rev_header_i = '0;
        bus.mem_rev_data_i = '0;
        #2 reset_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_tests++;
        if ({bus.mem_fwd_v_o, bus.mem_rev_ready_and_o, bus.ack_o, bus.err_o, bus.mem_fwd_last_o} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
                {bus.mem_fwd_v_o, bus.mem_rev_ready_and_o, bus.ack_o, bus.err_o, bus.mem_fwd_last_o});
        end
        n_tests++;
        if ({bus.dat_o, bus.mem_fwd_data_o} !== 128'h0 || bus.mem_fwd_header_o !== '0) begin
            n_fail++; $display("FAIL reset_regs: dat_o=%h fwd_data=%h hdr=%h expected 0",
                bus.dat_o, bus.mem_fwd_data_o, bus.mem_fwd_header_o);
        end
        reset_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_read_dword();
        do_xfer(37'h1000, 8'hFF, 1'b0, 64'h0, 3'b000, 0, 64'h1122334455667788, t, er, fn, h, fd, st, ex);
        n_tests++; if (t !== 3 || er !== 1'b0) begin n_fail++; $display("FAIL rd_dword_latency: got cycle %0d err %b expected 3 err 0", t, er); end
        n_tests++; if (h !== mk_hdr(4'd2, 40'h8000, 3'd3)) begin n_fail++; $display("FAIL rd_dword_hdr: got %h expected %h", h, mk_hdr(4'd2, 40'h8000, 3'd3)); end
        n_tests++; if (bus.dat_o !== 64'h1122334455667788) begin n_fail++; $display("FAIL rd_dword_data: got %h expected 1122334455667788", bus.dat_o); end
        n_tests++; if (fn !== 1 || ex !== 1'b0) begin n_fail++; $display("FAIL rd_dword_once: fwd cycles %0d extra %b expected 1 0", fn, ex); end
    endtask

    task automatic test_byte_write();
        do_xfer(37'h10, 8'h20, 1'b1, 64'h0000AB0000000000, 3'b000, 0, 64'hFFFF_FFFF_FFFF_FFFF, t, er, fn, h, fd, st, ex);
        n_tests++; if (h !== mk_hdr(4'd3, 40'h85, 3'd0)) begin n_fail++; $display("FAIL wr_byte_hdr: got %h expected %h", h, mk_hdr(4'd3, 40'h85, 3'd0)); end
        n_tests++; if (fd !== 64'hABABABABABABABAB) begin n_fail++; $display("FAIL wr_byte_data: got %h expected abababababababab", fd); end
        n_tests++; if (t !== 3 || ex !== 1'b0) begin n_fail++; $display("FAIL wr_byte_ack: got cycle %0d extra %b expected 3 0", t, ex); end
        n_tests++; if (bus.dat_o !== 64'h1122334455667788) begin n_fail++; $display("FAIL wr_keeps_dat_o: got %h expected 1122334455667788", bus.dat_o); end
    endtask

    task automatic test_half_read_backpressure();
        do_xfer(37'h20, 8'h0C, 1'b0, 64'h0, 3'b000, 5, 64'hBEEFBEEFBEEFBEEF, t, er, fn, h, fd, st, ex);
        n_tests++; if (t !== 8) begin n_fail++; $display("FAIL half_bp_latency: got cycle %0d expected 8", t); end
        n_tests++; if (fn !== 6 || st !== 1'b1) begin n_fail++; $display("FAIL half_bp_stable: fwd cycles %0d stable %b expected 6 1", fn, st); end
        n_tests++; if (h !== mk_hdr(4'd2, 40'h102, 3'd1)) begin n_fail++; $display("FAIL half_bp_hdr: got %h expected %h", h, mk_hdr(4'd2, 40'h102, 3'd1)); end
        n_tests++; if (bus.dat_o !== 64'hBEEFBEEFBEEF0000) begin n_fail++; $display("FAIL half_bp_data: got %h expected beefbeefbeef0000", bus.dat_o); end
    endtask

    task automatic test_illegal_sel();
        do_xfer(37'h30, 8'h05, 1'b0, 64'h0, 3'b000, 0, 64'h0, t, er, fn, h, fd, st, ex);
        n_tests++; if (t !== 1 || er !== 1'b1 || fn !== 0 || ex !== 1'b0) begin n_fail++; $display("FAIL err_sel05: cycle %0d err %b fwd %0d extra %b expected 1 1 0 0", t, er, fn, ex); end
        do_xfer(37'h31, 8'h00, 1'b1, 64'h0, 3'b000, 0, 64'h0, t, er, fn, h, fd, st, ex);
        n_tests++; if (t !== 1 || er !== 1'b1 || fn !== 0) begin n_fail++; $display("FAIL err_sel00: cycle %0d err %b fwd %0d expected 1 1 0", t, er, fn); end
        do_xfer(37'h3, 8'hF0, 1'b1, 64'hDEADBEEF_00000000, 3'b000, 0, 64'h0, t, er, fn, h, fd, st, ex);
        n_tests++; if (t !== 3 || er !== 1'b0) begin n_fail++; $display("FAIL after_err_ack: cycle %0d err %b expected 3 0", t, er); end
        n_tests++; if (h !== mk_hdr(4'd3, 40'h1C, 3'd2) || fd !== 64'hDEADBEEFDEADBEEF) begin n_fail++; $display("FAIL after_err_cmd: hdr %h data %h expected %h deadbeefdeadbeef", h, fd, mk_hdr(4'd3, 40'h1C, 3'd2)); end
    endtask

    task automatic test_reset_mid();
        bit reached;
        reached = 1'b0;
        bus.cyc_i = 1; bus.stb_i = 1; bus.adr_i = 37'h40; bus.sel_i = 8'hFF; bus.we_i = 0;
        bus.mem_fwd_ready_and_i = 1;
        for (int n = 0; n < 20 && !reached; n++) begin
            @(negedge clk_i);
            if (bus.mem_rev_ready_and_o) reached = 1'b1;
        end
        bus.mem_fwd_ready_and_i = 0;
        n_tests++; if (!reached) begin n_fail++; $display("FAIL rst_mid_reach_wait: got no WAIT expected WAIT within 20 cycles"); end
        reset_n_i = 1'b0;
        #1;
        n_tests++;
        if ({bus.mem_fwd_v_o, bus.mem_rev_ready_and_o, bus.ack_o, bus.err_o} !== 4'b0 || bus.dat_o !== 64'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs: ctrl %b dat_o %h expected 0000 0",
                {bus.mem_fwd_v_o, bus.mem_rev_ready_and_o, bus.ack_o, bus.err_o}, bus.dat_o);
        end
        bus.cyc_i = 0; bus.stb_i = 0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        do_xfer(37'h41, 8'h01, 1'b0, 64'h0, 3'b000, 0, 64'h7777777777777777, t, er, fn, h, fd, st, ex);
        n_tests++; if (t !== 3 || h !== mk_hdr(4'd2, 40'h208, 3'd0) || bus.dat_o !== 64'h7777777777777777) begin
            n_fail++; $display("FAIL rst_mid_recover: cycle %0d hdr %h dat_o %h expected 3 %h 7777777777777777", t, h, bus.dat_o, mk_hdr(4'd2, 40'h208, 3'd0));
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd;
        for (int i = 0; i < 4; i++) begin
            rd = 64'hA5A5_0000_0000_0000 + 64'(i);
            do_xfer(37'h100 + 37'(i), 8'hFF, 1'b0, 64'h0, 3'b010, 0, rd, t, er, fn, h, fd, st, ex);
            n_tests++;
            if (t !== 3 || h !== mk_hdr(4'd2, 40'h800 + 40'(i * 8), 3'd3) || bus.dat_o !== rd) begin
                n_fail++; $display("FAIL burst_beat%0d: cycle %0d hdr %h dat_o %h expected 3 %h %h",
                    i, t, h, bus.dat_o, mk_hdr(4'd2, 40'h800 + 40'(i * 8), 3'd3), rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_dword();
        test_byte_write();
        test_half_read_backpressure();
        test_illegal_sel();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
